// File: rtl/l2norm_arbiter_if.sv
// Bundle of every handshake/data signal between the stream sources, the norm
// engine and l2norm_arbiter. Latency: none, wires only. Backpressure: carried
// by the tready signals of the s_/m_/r_/o_ channels.
// Ports (signals): s_* requester beats in, m_* beats to engine, r_* engine
// result in, o_* result out to requesters, busy status.
// Modport slave is the arbiter's view; master is the surrounding environment.
interface l2norm_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*64-1:0] s_tdata;
  logic [NUM_REQ-1:0]    s_tvalid;
  logic [NUM_REQ-1:0]    s_tlast;
  logic [NUM_REQ-1:0]    s_tready;
  logic [63:0]           m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;
  logic [31:0]           r_tdata;
  logic                  r_tvalid;
  logic                  r_tready;
  logic [31:0]           o_tdata;
  logic [NUM_REQ-1:0]    o_tvalid;
  logic [NUM_REQ-1:0]    o_tready;
  logic                  busy;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready,
    input  r_tdata, r_tvalid,
    output r_tready,
    output o_tdata, o_tvalid,
    input  o_tready,
    output busy
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready,
    output r_tdata, r_tvalid,
    input  r_tready,
    input  o_tdata, o_tvalid,
    output o_tready,
    input  busy
  );
endinterface

// File: rtl/l2norm_arbiter.sv
// Round-robin arbiter sharing one L2-norm engine among NUM_REQ vector streams,
// locking the grant for a whole vector and routing results back by an in-order tag FIFO.
// Latency: grant one cycle after valid seen in IDLE; beat and result paths are combinational.
// Backpressure: m_tready passes straight to the granted s_tready; o_tready[head] drives
// r_tready; a full tag FIFO only holds off new grants.
// Ports: clock, reset (sync, active-high), bus (l2norm_arbiter_if.slave: s_*, m_*, r_*, o_*, busy).
module l2norm_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  l2norm_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(TAG_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] g;         // granted requester
  logic [IW-1:0] p;         // round-robin start point
  logic [IW-1:0] pick;
  logic          pick_vld;
  int            idx;

  logic [IW-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [IW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          vec_done;

  // Scan from the farthest offset down so the requester closest to p wins.
  always_comb begin
    pick     = p;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.s_tvalid[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Beat path: only the granted requester is visible, and only while in BURST,
  // so the engine sees zeros between vectors.
  always_comb begin
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.s_tready = '0;
    if (state == BURST) begin
      bus.m_tdata     = bus.s_tdata[int'(g)*64 +: 64];
      bus.m_tvalid    = bus.s_tvalid[g];
      bus.m_tlast     = bus.s_tlast[g];
      bus.s_tready[g] = bus.m_tready;
    end
  end

  assign vec_done   = (state == BURST) && bus.m_tvalid && bus.m_tready && bus.m_tlast;
  assign fifo_full  = (count == (AW + 1)'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  // Full is judged on the registered count, so a pop in the same cycle does
  // not let a grant through until the next cycle.
  assign push       = (state == IDLE) && pick_vld && !fifo_full;
  assign head       = tag_mem[rd_ptr];

  // Result path: results come back in grant order, so the FIFO head names the owner.
  // With nothing in flight a stray result is stalled rather than dropped.
  always_comb begin
    bus.o_tdata  = bus.r_tdata;
    bus.o_tvalid = '0;
    bus.r_tready = 1'b0;
    if (!fifo_empty) begin
      bus.o_tvalid[head] = bus.r_tvalid;
      bus.r_tready       = bus.o_tready[head];
    end
  end

  assign pop      = bus.r_tvalid && bus.r_tready;
  assign bus.busy = (state == BURST) || !fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      g      <= '0;
      p      <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            g     <= pick;
            state <= BURST;
          end
        end
        BURST: begin
          if (vec_done) begin
            state <= IDLE;
            p     <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= pick;
  end
endmodule

// File: tb/tb_l2norm_arbiter.sv
// Directed bench for l2norm_arbiter: a per-cycle vector table plus a reset-mid-burst sequence.
module tb_l2norm_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  l2norm_arbiter_if #(.NUM_REQ(4)) bus ();

  l2norm_arbiter #(.NUM_REQ(4), .TAG_DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       rb;    // pulse reset before this row
    logic [3:0] sv;
    logic [3:0] sl;
    logic       mr;
    logic       rv;
    logic [3:0] orr;
    logic [3:0] esr;
    logic       emv;
    logic       eml;
    logic [1:0] eg;
    logic [3:0] eov;
    logic       err;
    logic       eb;
  } vec_t;

  vec_t        tab[$];
  logic [63:0] req_data [4];

  function automatic vec_t mk(input logic rb, input logic [3:0] sv, input logic [3:0] sl,
                              input logic mr, input logic rv, input logic [3:0] orr,
                              input logic [3:0] esr, input logic emv, input logic eml,
                              input logic [1:0] eg, input logic [3:0] eov,
                              input logic err, input logic eb);
    vec_t v;
    v.rb = rb; v.sv = sv; v.sl = sl; v.mr = mr; v.rv = rv; v.orr = orr;
    v.esr = esr; v.emv = emv; v.eml = eml; v.eg = eg; v.eov = eov; v.err = err; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input logic [3:0] sv, input logic [3:0] sl, input logic mr,
                       input logic rv, input logic [31:0] rd, input logic [3:0] orr);
    bus.s_tvalid = sv;
    bus.s_tlast  = sl;
    bus.m_tready = mr;
    bus.r_tvalid = rv;
    bus.r_tdata  = rd;
    bus.o_tready = orr;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(4'b0, 4'b0, 1'b0, 1'b0, 32'd0, 4'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [3:0] esr, input logic emv,
                       input logic eml, input logic [63:0] emd, input logic [3:0] eov,
                       input logic err, input logic eb, input logic [31:0] eod);
    logic [107:0] got;
    logic [107:0] exp;
    got = {bus.s_tready, bus.m_tvalid, bus.m_tlast, bus.m_tdata,
           bus.o_tvalid, bus.r_tready, bus.busy, bus.o_tdata};
    exp = {esr, emv, eml, emd, eov, err, eb, eod};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (s_tready,m_tvalid,m_tlast,m_tdata,o_tvalid,r_tready,busy,o_tdata)",
               name, got, exp);
    end
  endtask

  initial begin
    logic [63:0] emd;
    logic [31:0] rd;

    for (int i = 0; i < 4; i++) req_data[i] = {8'(8'hA0 + i), 56'h01_0101_0101_0101};
    bus.s_tdata = {req_data[3], req_data[2], req_data[1], req_data[0]};
    drive(4'b0, 4'b0, 1'b0, 1'b0, 32'd0, 4'b0);

    // A: requester 1, 3-beat vector; result held back while o_tready[1] low; stray result
    tab.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 4'b1111, 4'b0010, 1, 0, 1, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 4'b1111, 4'b0010, 1, 0, 1, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b0010, 4'b0010, 1, 0, 4'b1111, 4'b0010, 1, 1, 1, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1101, 4'b0000, 0, 0, 0, 4'b0010, 0, 1));
    tab.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0010, 1, 1));
    tab.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // B: all requesters valid, 2-beat vectors: order 0,1,2,3,0 with one bubble each
    tab.push_back(mk(1, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0001, 1, 0, 0, 4'b0001, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0001, 1, 1, 4'b1111, 4'b0001, 1, 1, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0010, 1, 0, 1, 4'b0010, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0010, 1, 1, 4'b1111, 4'b0010, 1, 1, 1, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0100, 1, 0, 2, 4'b0100, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0100, 1, 1, 4'b1111, 4'b0100, 1, 1, 2, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b1000, 1, 0, 3, 4'b1000, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1000, 1, 1, 4'b1111, 4'b1000, 1, 1, 3, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b1111, 4'b0000, 1, 1, 4'b1111, 4'b0001, 1, 0, 0, 4'b0001, 1, 1));
    // C: requester 2 locked while 0 raises valid (with a stall), then 3 scanned before 0
    tab.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0100, 1, 0, 2, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b0101, 4'b0000, 1, 0, 4'b0000, 4'b0100, 1, 0, 2, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b0101, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 2, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b0101, 4'b0100, 1, 0, 4'b0000, 4'b0100, 1, 1, 2, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1001, 4'b1000, 1, 0, 4'b0000, 4'b1000, 1, 1, 3, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0001, 1, 1, 0, 4'b0000, 0, 1));
    // D: single-beat vectors, no results accepted: 4 grants then full; pop releases one grant
    tab.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0001, 1, 1, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0010, 1, 1, 1, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0100, 1, 1, 2, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b1000, 1, 1, 3, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0001, 4'b0000, 0, 0, 0, 4'b0001, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0001, 1, 1, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 4'b1101, 4'b0000, 0, 0, 0, 4'b0010, 0, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010, 1, 1));
    // push and pop in the same cycle keep the count, checked by the grant that follows
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'b0100, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b1111, 4'b0010, 1, 1, 1, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b1111, 4'b0100, 1, 1, 2, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));
    tab.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 1));

    foreach (tab[i]) begin
      if (tab[i].rb) do_reset();
      else begin
        @(posedge clock);
        #1;
      end
      rd = 32'(1000 + i);
      drive(tab[i].sv, tab[i].sl, tab[i].mr, tab[i].rv, rd, tab[i].orr);
      @(negedge clock);
      emd = tab[i].emv ? req_data[tab[i].eg] : 64'd0;
      check($sformatf("row%0d", i), tab[i].esr, tab[i].emv, tab[i].eml, emd,
            tab[i].eov, tab[i].err, tab[i].eb, rd);
    end

    // Reset state, then reset during beat 2 of a 4-beat vector taken with p=3.
    do_reset();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0, 4'b0000);
    @(negedge clock);
    check("reset_state", 4'b0000, 0, 0, 64'd0, 4'b0000, 0, 0, 32'd0);
    drive(4'b0100, 4'b0100, 1'b1, 1'b0, 32'd0, 4'b1111);     // grant 2
    @(posedge clock); #1;                                     // single beat of 2, p -> 3
    @(posedge clock); #1;
    drive(4'b0010, 4'b0000, 1'b1, 1'b0, 32'd0, 4'b1111);     // grant 1 (scan 3,0,1)
    @(posedge clock); #1;                                     // beat 1 of 4
    @(posedge clock); #1;                                     // beat 2 of 4 on the bus
    @(negedge clock);
    check("beat2_before_reset", 4'b0010, 1, 0, req_data[1], 4'b0000, 1, 1, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    drive(4'b1010, 4'b0000, 1'b1, 1'b1, 32'd77, 4'b1111);
    @(negedge clock);
    check("after_mid_reset", 4'b0000, 0, 0, 64'd0, 4'b0000, 0, 0, 32'd77);
    @(posedge clock); #1;                                     // p back at 0 picks 1, not 3
    @(negedge clock);
    check("regrant_from_p0", 4'b0010, 1, 0, req_data[1], 4'b0010, 1, 1, 32'd77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l2norm_arbiter.md
# l2norm_arbiter

Round-robin arbiter sharing one L2-norm accumulate engine (64-bit AXIS in, 32-bit result out) among NUM_REQ vector streams. Grants at whole-vector granularity (locked until tlast), records each granted requester's ID in an in-order tag FIFO, and steers each returned 32-bit result to the matching requester's result port. Sits between the per-channel stream sources and the norm engine.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TAG_DEPTH, 4, tag FIFO depth = max vectors in flight (power of 2, ≥2)
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_tdata  in  NUM_REQ*64  requester vector beats; requester i at bits [64i+63:64i]
- s_tvalid  in  NUM_REQ  per-requester beat valid
- s_tlast  in  NUM_REQ  per-requester last beat of vector
- s_tready  out  NUM_REQ  per-requester beat accept
- m_tdata  out  64  beat to engine
- m_tvalid  out  1  beat valid to engine
- m_tlast  out  1  last beat to engine
- m_tready  in  1  engine accepts beat
- r_tdata  in  32  engine result
- r_tvalid  in  1  engine result valid
- r_tready  out  1  result accept to engine
- o_tdata  out  32  result to requesters (shared bus)
- o_tvalid  out  NUM_REQ  one-hot result valid
- o_tready  in  NUM_REQ  per-requester result accept
- busy  out  1  high while in BURST or tag FIFO non-empty

## Operation
- FSM states IDLE, BURST. Registers: grant index g, round-robin pointer p, tag FIFO (entries of clog2(NUM_REQ) bits, count 0..TAG_DEPTH).
- IDLE: if any s_tvalid and count < TAG_DEPTH, pick first requester with s_tvalid scanning p, p+1, … modulo NUM_REQ; register g, push g into tag FIFO, go BURST. Otherwise stay. No beats pass in IDLE (all s_tready=0, m_tvalid=0).
- BURST: combinational pass-through of requester g only: m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], m_tlast=s_tlast[g], s_tready[g]=m_tready, all other s_tready=0.
- On handshake (m_tvalid&m_tready&m_tlast): go IDLE, p <= (g+1) mod NUM_REQ.
- Grant never changes mid-vector, regardless of other requesters' tvalid.
- Result path (independent of FSM): head = FIFO head tag. If count>0: o_tvalid = one-hot(head) & {NUM_REQ{r_tvalid}}, r_tready = o_tready[head]. If count=0: o_tvalid=0, r_tready=0 (stray result stalled). o_tdata = r_tdata always.
- Pop on r_tvalid&r_tready. Push and pop in same cycle: count unchanged, both take effect.
- Full FIFO blocks new grants only; current BURST always completes.

## Timing
- Reset values: state IDLE, p=0, g=0, count=0; s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0 (mux of g=0 gated by valid → drive 0 when not BURST), r_tready=0, o_tvalid=0, busy=0.
- Grant latency: requester's s_tvalid seen in IDLE at cycle t → BURST at t+1, first beat may transfer at t+1.
- One idle bubble cycle between consecutive vectors (tlast cycle → IDLE cycle → next grant).
- Beat path and result path are zero-latency combinational; no registered data stages.
- Full test: count==TAG_DEPTH at IDLE evaluation blocks grant that cycle even if a pop occurs same cycle; grant happens next cycle.
- Reset mid-BURST: returns to IDLE, FIFO cleared; partial vector in engine is the engine's responsibility (reset together).
- Single-beat vector (tlast on first beat): BURST lasts one cycle.

## Test plan
- Single requester 1 sends 3-beat vector of all 0x01 bytes (sum 24) → grant cycle after valid, 3 beats on m_*, engine result 24 appears on o_tvalid=0b0010 with o_tdata=24.
- All 4 requesters valid continuously with 2-beat vectors → grant order 0,1,2,3,0; exactly one bubble between vectors; no interleaving of beats.
- Requester 2 holds vector while requester 0 asserts valid mid-burst → grant stays 2 until tlast, then p=3 → 3 scanned first, 0 granted only if 3 idle.
- TAG_DEPTH=4, o_tready all 0, 6 vectors offered → 4 granted, 5th waits in IDLE with busy=1; raise o_tready[head] → one pop, 5th granted next cycle.
- Results returned while o_tready of head requester low → r_tready=0, r_tdata held by engine, FIFO not popped; assert o_tready → pop, result to correct one-hot port.
- Reset asserted during beat 2 of 4 → next cycle all outputs at reset values, count=0, p=0.
